// File: rtl/hash_pkg.sv
// Shared types and constants for the lookup3 key loader: FSM states, block
// geometry and the issued-word-count helper.
`timescale 1ns/1ps
package hash_pkg;

  localparam int MAX_BYTES   = 255;
  localparam int MIX_GAP     = 4;
  localparam int BLOCK_WORDS = 3;
  localparam int BLOCK_BYTES = 12;
  localparam int BUF_WORDS   = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DROP,
    S_ISSUE,
    S_GAP,
    S_WAIT
  } state_t;

  // Whole 3-word blocks needed to cover len bytes (a zero-length key never occurs).
  function automatic logic [7:0] words_for_len(input logic [7:0] len);
    logic [8:0] blocks;
    blocks = (9'(len) + 9'(BLOCK_BYTES - 1)) / 9'(BLOCK_BYTES);
    return 8'(blocks * 9'(BLOCK_WORDS));
  endfunction

endpackage

// File: rtl/hash_key_loader_if.sv
// Byte-stream input and lookup3 core-side signals of the key loader.
// Handshake: a byte moves on a rising edge where in_valid & in_ready are both 1.
`timescale 1ns/1ps
interface hash_key_loader_if;
  import hash_pkg::*;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        enable;
  logic        onloop;
  logic [7:0]  wcount;
  logic [31:0] word;
  logic [7:0]  key_length;
  logic [7:0]  interval;
  logic        hash_valid;
  logic        err;
  state_t      dbg_state;

  modport master (
    output in_valid, in_data, in_last, hash_valid,
    input  in_ready, enable, onloop, wcount, word, key_length, interval, err, dbg_state
  );

  modport slave (
    input  in_valid, in_data, in_last, hash_valid,
    output in_ready, enable, onloop, wcount, word, key_length, interval, err, dbg_state
  );

endinterface

// File: rtl/hash_key_buf.sv
// 64x32 single-port key buffer with per-byte-lane write enables and a
// registered read port.
`timescale 1ns/1ps
module hash_key_buf import hash_pkg::*; (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [BUF_WORDS];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we && be[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hash_key_loader.sv
// Buffers a byte-stream key and replays it to the lookup3 core in 3-word blocks.
// HASH_KEY_LOADER_BYTESWAP_EN selects big-endian byte packing within each word.
`timescale 1ns/1ps
module hash_key_loader import hash_pkg::*; (
  input  logic CLK,
  input  logic RST,
  hash_key_loader_if.slave bus
);

  state_t      state;
  logic [7:0]  len;
  logic [7:0]  nlen;
  logic [7:0]  rd_idx;
  logic [1:0]  sub;
  logic [7:0]  gap_cnt;
  logic [7:0]  rem;
  logic [7:0]  w_total;
  logic [7:0]  key_len;
  logic        in_ready;
  logic        err;
  logic        accept;

  logic [1:0]  lane;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [5:0]  buf_addr;
  logic [31:0] rdata;

  logic        s1_valid;
  logic        s1_onloop;
  logic [7:0]  s1_wcount;
  logic        in_key;
  logic        issue_en;
  logic        issue_onloop;
  logic [7:0]  issue_wcount;
  logic [31:0] issue_word;

  assign accept = bus.in_valid & in_ready;
  assign nlen   = len + 8'd1;

`ifdef HASH_KEY_LOADER_BYTESWAP_EN
  assign lane = ~len[1:0];
`else
  assign lane = len[1:0];
`endif

  // The first byte of each word writes all lanes so stale bytes read back as 0.
  always_comb begin
    wr_en    = accept && (state == S_IDLE || (state == S_FILL && len != 8'(MAX_BYTES)));
    wr_data  = 32'(bus.in_data) << {lane, 3'b000};
    wr_be    = (len[1:0] == 2'd0) ? 4'hF : (4'b0001 << lane);
    buf_addr = wr_en ? len[7:2] : rd_idx[5:0];
  end

  hash_key_buf u_buf (
    .clk   (CLK),
    .we    (wr_en),
    .be    (wr_be),
    .addr  (buf_addr),
    .wdata (wr_data),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      len      <= '0;
      rd_idx   <= '0;
      sub      <= '0;
      gap_cnt  <= '0;
      rem      <= '0;
      w_total  <= '0;
      key_len  <= '0;
      in_ready <= 1'b1;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            if (state == S_FILL && len == 8'(MAX_BYTES)) begin
              err   <= 1'b1;
              len   <= '0;
              state <= bus.in_last ? S_IDLE : S_DROP;
            end else if (bus.in_last) begin
              key_len  <= nlen;
              w_total  <= words_for_len(nlen);
              rem      <= nlen;
              rd_idx   <= '0;
              sub      <= '0;
              len      <= '0;
              in_ready <= 1'b0;
              state    <= S_ISSUE;
            end else begin
              len   <= nlen;
              state <= S_FILL;
            end
          end
        end
        S_DROP: begin
          if (accept && bus.in_last) state <= S_IDLE;
        end
        S_ISSUE: begin
          rd_idx <= rd_idx + 8'd1;
          sub    <= sub + 2'd1;
          if (sub == 2'(BLOCK_WORDS - 1)) begin
            sub <= '0;
            if (rd_idx == w_total - 8'd1) begin
              state <= S_WAIT;
            end else begin
              rem     <= rem - 8'(BLOCK_BYTES);
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == 8'(MIX_GAP - 1)) state <= S_ISSUE;
        end
        S_WAIT: begin
          if (bus.hash_valid) begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Two-stage read pipeline: buffer read, then output register with padding mask.
  assign in_key = {s1_wcount, 2'b00} < {2'b00, key_len};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_valid     <= 1'b0;
      s1_onloop    <= 1'b0;
      s1_wcount    <= '0;
      issue_en     <= 1'b0;
      issue_onloop <= 1'b0;
      issue_wcount <= '0;
      issue_word   <= '0;
    end else begin
      s1_valid     <= (state == S_ISSUE);
      s1_onloop    <= (rem > 8'(BLOCK_BYTES));
      s1_wcount    <= rd_idx;
      issue_en     <= s1_valid;
      issue_onloop <= s1_valid & s1_onloop;
      issue_wcount <= s1_valid ? s1_wcount : '0;
      issue_word   <= (s1_valid && in_key) ? rdata : '0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.enable     = issue_en;
  assign bus.onloop     = issue_onloop;
  assign bus.wcount     = issue_wcount;
  assign bus.word       = issue_word;
  assign bus.key_length = key_len;
  assign bus.interval   = 8'(MIX_GAP);
  assign bus.err        = err;
  assign bus.dbg_state  = state;

endmodule
